// File: rtl/const_div_pkg.sv
// Shared types and defaults for the sequential divide-by-constant block.
package const_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DIVISOR = 11;
    localparam int DEF_CHUNK   = 2;

    // Bits needed to hold any remainder 0..d-1.
    function automatic int calc_rw(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/const_div_step.sv
// One digit-serial divide step: {rem_in, chunk_in} split into quotient digit and new remainder.
module const_div_step #(
    parameter int DIVISOR = 11,
    parameter int CHUNK   = 2,
    parameter int RW      = 4
) (
    input  logic [RW-1:0]    rem_in,
    input  logic [CHUNK-1:0] chunk_in,
    output logic [CHUNK-1:0] q_digit,
    output logic [RW-1:0]    rem_out
);

    localparam int TW = RW + CHUNK;
    localparam int NE = 1 << TW;

    typedef logic [NE-1:0][CHUNK+RW-1:0] tbl_t;

    // Entries with rem_in >= DIVISOR are unreachable; their digit is simply truncated.
    function automatic tbl_t build_tbl();
        tbl_t tb;
        for (int i = 0; i < NE; i++) begin
            tb[i] = {CHUNK'(i / DIVISOR), RW'(i % DIVISOR)};
        end
        return tb;
    endfunction

    localparam tbl_t TBL = build_tbl();

    assign {q_digit, rem_out} = TBL[{rem_in, chunk_in}];

endmodule

// File: rtl/const_div_seq.sv
// Sequenced divide-by-constant: retires CHUNK dividend bits per cycle, MSB first.
module const_div_seq
    import const_div_pkg::*;
#(
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  DIVISOR = DEF_DIVISOR,
    parameter int  CHUNK   = DEF_CHUNK,
    localparam int RW      = calc_rw(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [RW-1:0]    out_rem,
    output logic             busy
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [RW-1:0]    rem_q,   rem_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic [CHUNK-1:0] dig;
    logic [RW-1:0]    step_rem;

    const_div_step #(
        .DIVISOR (DIVISOR),
        .CHUNK   (CHUNK),
        .RW      (RW)
    ) u_step (
        .rem_in   (rem_q),
        .chunk_in (shift_q[WIDTH-1 -: CHUNK]),
        .q_digit  (dig),
        .rem_out  (step_rem)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    quot_d  = '0;
                    rem_d   = '0;
                    cnt_d   = CW'(STEPS - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rem_d   = step_rem;
                quot_d  = (quot_q << CHUNK) | WIDTH'(dig);
                shift_d = shift_q << CHUNK;
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything; visible results keep their last value.
        if (flush) begin
            state_d = ST_IDLE;
            shift_d = shift_q;
            quot_d  = quot_q;
            rem_d   = rem_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_quot  = quot_q;
    assign out_rem   = rem_q;

endmodule

// File: tb/tb_const_div_seq.sv
// Directed and randomized checks of const_div_seq against plain integer division.
module tb_const_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_quot;
    logic [3:0]  out_rem;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rnd_done = 0;
    logic rnd_go = 1'b0;

    always #5 clk = ~clk;

    const_div_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present x, wait for out_valid with out_ready held low; returns latency in cycles.
    task automatic start_wait(input logic [31:0] x, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_data = x;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    task automatic run_div(input logic [31:0] x, input logic [31:0] eq, input logic [3:0] er,
                           input string tag);
        int lat;
        @(negedge clk);
        chk({tag, ":in_ready"}, 64'(in_ready), 64'(1));
        out_ready = 1'b0;
        start_wait(x, lat);
        chk({tag, ":latency"}, 64'(lat), 64'(16));
        chk({tag, ":quot"}, 64'(out_quot), 64'(eq));
        chk({tag, ":rem"}, 64'(out_rem), 64'(er));
        chk({tag, ":busy"}, 64'(busy), 64'(1));
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":ready_after"}, 64'(in_ready), 64'(1));
        chk({tag, ":valid_after"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] x;
        logic [31:0] q_hold;
        logic [3:0]  r_hold;

        // Reset values while rst is held
        #3;
        chk("rst:in_ready", 64'(in_ready), 64'(1));
        chk("rst:out_valid", 64'(out_valid), 64'(0));
        chk("rst:busy", 64'(busy), 64'(0));
        chk("rst:quot", 64'(out_quot), 64'(0));
        chk("rst:rem", 64'(out_rem), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_div(32'd1234567890, 32'd112233444, 4'd6, "basic");
        run_div(32'hFFFFFFFF, 32'd390451572, 4'd3, "allones");
        run_div(32'd0, 32'd0, 4'd0, "zero");
        run_div(32'd10, 32'd0, 4'd10, "ten");
        run_div(32'd121, 32'd11, 4'd0, "d121");

        // Back-pressure: hold DONE for 20 cycles, pulse in_valid meanwhile
        x = 32'd987654321;
        start_wait(x, lat);
        chk("bp:latency", 64'(lat), 64'(16));
        for (int i = 0; i < 20; i++) begin
            chk("bp:quot", 64'(out_quot), 64'(x / 11));
            chk("bp:rem", 64'(out_rem), 64'(x % 11));
            chk("bp:valid", 64'(out_valid), 64'(1));
            chk("bp:in_ready", 64'(in_ready), 64'(0));
            in_valid = (i == 5);
            in_data = 32'd55;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp:valid_after", 64'(out_valid), 64'(0));
        chk("bp:busy_after", 64'(busy), 64'(0));
        chk("bp:quot_after", 64'(out_quot), 64'(x / 11));

        // Flush 5 cycles into RUN
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd5000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush:in_ready", 64'(in_ready), 64'(1));
        chk("flush:busy", 64'(busy), 64'(0));
        seen = 0;
        repeat (20) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk("flush:no_valid", 64'(seen), 64'(0));
        run_div(32'd1000, 32'd90, 4'd10, "post_flush");

        // Flush beats a same-cycle in_valid in IDLE
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'd77;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle:busy", 64'(busy), 64'(0));
        chk("flush_idle:in_ready", 64'(in_ready), 64'(1));

        // Flush beats a same-cycle out_ready in DONE; results keep last value
        x = 32'd3141592653;
        start_wait(x, lat);
        q_hold = 32'(x / 11);
        r_hold = 4'(x % 11);
        chk("flush_done:latency", 64'(lat), 64'(16));
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_done:valid", 64'(out_valid), 64'(0));
        chk("flush_done:in_ready", 64'(in_ready), 64'(1));
        chk("flush_done:quot", 64'(out_quot), 64'(q_hold));
        chk("flush_done:rem", 64'(out_rem), 64'(r_hold));

        // Asynchronous reset mid-RUN
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hFFFFFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst:in_ready", 64'(in_ready), 64'(1));
        chk("arst:valid", 64'(out_valid), 64'(0));
        chk("arst:busy", 64'(busy), 64'(0));
        chk("arst:quot", 64'(out_quot), 64'(0));
        chk("arst:rem", 64'(out_rem), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        run_div(32'd12345, 32'd1122, 4'd3, "post_rst");

        // Random run across configurations
        rnd_go = 1'b1;
        seen = 0;
        while (rnd_done < 12 && seen < 80000) begin
            @(posedge clk); seen++;
        end
        chk("rnd:all_done", 64'(rnd_done), 64'(12));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    localparam int NR = 850;

    for (genvar g = 0; g < 12; g++) begin : g_cfg
        localparam int C   = (g < 4) ? 1 : (g < 8) ? 2 : 4;
        localparam int D   = (g % 4 == 0) ? 3 : (g % 4 == 1) ? 7 : (g % 4 == 2) ? 11 : 16;
        localparam int RWG = $clog2(D);

        logic           iv = 1'b0;
        logic           ir;
        logic [31:0]    idata = '0;
        logic           ov;
        logic           ordy = 1'b0;
        logic [31:0]    oq;
        logic [RWG-1:0] orm;
        logic           bz;

        const_div_seq #(.WIDTH(32), .DIVISOR(D), .CHUNK(C)) u_rdut (
            .clk       (clk),
            .rst       (rst),
            .flush     (1'b0),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_data   (idata),
            .out_valid (ov),
            .out_ready (ordy),
            .out_quot  (oq),
            .out_rem   (orm),
            .busy      (bz)
        );

        initial begin
            logic [31:0] x;
            int lat;
            while (!rnd_go) @(posedge clk);
            for (int n = 0; n < NR; n++) begin
                x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
                @(negedge clk);
                chk("rnd:in_ready", 64'(ir), 64'(1));
                iv = 1'b1; idata = x;
                @(posedge clk); @(negedge clk);
                iv = 1'b0;
                lat = 0;
                while (!ov && lat < 200) begin
                    @(posedge clk); lat++; @(negedge clk);
                end
                chk("rnd:latency", 64'(lat), 64'(32 / C));
                chk("rnd:quot", 64'(oq), 64'(x / D));
                chk("rnd:rem", 64'(orm), 64'(x % D));
                chk("rnd:rem_lt_div", 64'(orm < D), 64'(1));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ordy = 1'b1;
                @(posedge clk); @(negedge clk);
                ordy = 1'b0;
            end
            rnd_done++;
        end
    end

endmodule
